// File: rtl/ppm_capture_axil.sv
// PPM pulse-train decoder with an AXI4-Lite register front end.
// Measures rising-edge intervals per channel and publishes complete frames atomically.
module ppm_capture_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 20,
    parameter int SYNC_MIN_DEFAULT   = 250000
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              ppm_in,
    output logic                              frame_irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_CAPTURE} state_t;

    logic clk, rst;
    assign clk = S_AXI_ACLK;
    assign rst = S_AXI_ARESET;

    // AXI handshake state
    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic [AW-3:0] araddr_q, araddr_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Configuration registers
    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] sync_min_q, sync_min_d;
    logic [DW-1:0] irq_en_q, irq_en_d;
    logic [DW-1:0] scratch_q, scratch_d;

    // Capture datapath and FSM
    logic                 ppm_s1_q, ppm_s1_d;
    logic                 ppm_s2_q, ppm_s2_d;
    logic                 ppm_s3_q, ppm_s3_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           ch_idx_q, ch_idx_d;
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CH];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_q [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_d [NUM_CH];
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 timeout_q, timeout_d;
    logic                 frame_irq_q, frame_irq_d;

    logic          wren, rden, strobe, long_gap;
    int            wr_word, rd_word;
    logic [DW-1:0] rd_mux;
    logic [CNT_WIDTH-1:0] cnt_inc;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [DW/8-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        awready_d     = 1'b0;
        bvalid_d      = bvalid_q;
        arready_d     = 1'b0;
        araddr_d      = araddr_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        ctrl_d        = ctrl_q;
        sync_min_d    = sync_min_q;
        irq_en_d      = irq_en_q;
        scratch_d     = scratch_q;
        ppm_s1_d      = ppm_in;
        ppm_s2_d      = ppm_s1_q;
        ppm_s3_d      = ppm_s2_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_idx_d      = ch_idx_q;
        shadow_d      = shadow_q;
        ch_d          = ch_q;
        frame_count_d = frame_count_q;
        frame_valid_d = frame_valid_q;
        timeout_d     = timeout_q;
        frame_irq_d   = 1'b0;

        wr_word = int'(S_AXI_AWADDR[AW-1:2]);
        rd_word = int'(araddr_q);
        wren    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
        rden    = arready_q && S_AXI_ARVALID && !rvalid_q;

        // Read mux samples register state before this cycle's updates
        case (rd_word)
            0:       rd_mux = ctrl_q;
            1:       rd_mux = sync_min_q;
            2:       rd_mux = irq_en_q;
            3:       rd_mux = scratch_q;
            8:       rd_mux = {14'd0, timeout_q, frame_valid_q, frame_count_q};
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_word == 4 + i) rd_mux = DW'(ch_q[i]);
        end

        if (!awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q) awready_d = 1'b1;
        if (wren) begin
            bvalid_d = 1'b1;
            case (wr_word)
                0:       ctrl_d     = apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
                1:       sync_min_d = apply_strb(sync_min_q, S_AXI_WDATA, S_AXI_WSTRB);
                2:       irq_en_d   = apply_strb(irq_en_q, S_AXI_WDATA, S_AXI_WSTRB);
                3:       scratch_d  = apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (!arready_q && S_AXI_ARVALID && !rvalid_q) begin
            arready_d = 1'b1;
            araddr_d  = S_AXI_ARADDR[AW-1:2];
        end
        if (rden) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        strobe   = ppm_s2_q && !ppm_s3_q;
        long_gap = cnt_q >= sync_min_q[CNT_WIDTH-1:0];
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        if (!ctrl_q[0]) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            ch_idx_d = 3'd0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_WAIT_SYNC;
        end else begin
            cnt_d = strobe ? CNT_ONE : cnt_inc;
            if (strobe) begin
                if (long_gap) begin
                    // A sync gap always (re)starts a frame, discarding partial captures
                    state_d  = ST_CAPTURE;
                    ch_idx_d = 3'd0;
                end else if (state_q == ST_CAPTURE) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_idx_q == 3'(i)) shadow_d[i] = cnt_q;
                    end
                    if (ch_idx_q == 3'(NUM_CH - 1)) begin
                        for (int i = 0; i < NUM_CH - 1; i++) ch_d[i] = shadow_q[i];
                        ch_d[NUM_CH-1] = cnt_q;
                        frame_count_d  = frame_count_q + 16'd1;
                        frame_valid_d  = 1'b1;
                        frame_irq_d    = irq_en_q[0];
                        state_d        = ST_WAIT_SYNC;
                        ch_idx_d       = 3'd0;
                    end else begin
                        ch_idx_d = ch_idx_q + 3'd1;
                    end
                end
            end else if (cnt_q == CNT_NEAR) begin
                // Fires once as the counter reaches saturation, not every saturated cycle
                frame_valid_d = 1'b0;
                timeout_d     = 1'b1;
                state_d       = ST_WAIT_SYNC;
                ch_idx_d      = 3'd0;
            end
        end

        if (wren && wr_word == 0) timeout_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
            araddr_q      <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            ctrl_q        <= '0;
            sync_min_q    <= DW'(SYNC_MIN_DEFAULT);
            irq_en_q      <= '0;
            scratch_q     <= '0;
            ppm_s1_q      <= 1'b0;
            ppm_s2_q      <= 1'b0;
            ppm_s3_q      <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ch_idx_q      <= 3'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                ch_q[i]     <= '0;
            end
            frame_count_q <= 16'd0;
            frame_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            frame_irq_q   <= 1'b0;
        end else begin
            awready_q     <= awready_d;
            bvalid_q      <= bvalid_d;
            arready_q     <= arready_d;
            araddr_q      <= araddr_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            ctrl_q        <= ctrl_d;
            sync_min_q    <= sync_min_d;
            irq_en_q      <= irq_en_d;
            scratch_q     <= scratch_d;
            ppm_s1_q      <= ppm_s1_d;
            ppm_s2_q      <= ppm_s2_d;
            ppm_s3_q      <= ppm_s3_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ch_idx_q      <= ch_idx_d;
            shadow_q      <= shadow_d;
            ch_q          <= ch_d;
            frame_count_q <= frame_count_d;
            frame_valid_q <= frame_valid_d;
            timeout_q     <= timeout_d;
            frame_irq_q   <= frame_irq_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign frame_irq     = frame_irq_q;

endmodule

// File: tb/tb_ppm_capture_axil.sv
// Directed bench for ppm_capture_axil: register map, frame capture, short frame,
// timeout (12-bit counter build), handshake back-pressure and mid-frame reset.
module tb_ppm_capture_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, frame_irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ppm_in = 1'b0;

    int n_assert = 0, n_fail = 0;
    int cyc_n = 0, irq_cnt = 0, irq_cyc = 0, last_rise = 0;

    always #5 clk = ~clk;

    ppm_capture_axil #(.CNT_WIDTH(12)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ppm_in(ppm_in), .frame_irq(frame_irq)
    );

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (frame_irq) begin
            irq_cnt <= irq_cnt + 1;
            irq_cyc <= cyc_n;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int k;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        while (!awready && k < 20) begin @(negedge clk); k++; end
        check("aw_handshake_in_time", 32'(k < 20), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 20) begin @(negedge clk); k++; end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin @(negedge clk); k++; end
        check("r_valid_in_time", 32'(k < 20), 32'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        check("bresp_okay", 32'(r), 32'd0);
    endtask

    // Rising edge on ppm_in exactly gap cycles after the previous one, then a 10-cycle high.
    task automatic rise_after(input int gap);
        check("rise_schedule_reachable", 32'(cyc_n <= last_rise + gap), 32'd1);
        while (cyc_n < last_rise + gap) @(negedge clk);
        ppm_in = 1'b1;
        last_rise = cyc_n;
        repeat (10) @(negedge clk);
        ppm_in = 1'b0;
    endtask

    initial begin
        logic [31:0] d, held;
        logic [1:0]  r;
        logic        stay_ok, extra_aw;

        // 1: reset values and RW registers
        #100;
        check("outputs_in_reset", {24'd0, awready, wready, bvalid, arready, rvalid, frame_irq, bresp == 2'b00, rdata == 32'd0},
              32'h0000_0003);
        #100 rst = 1'b0;
        for (int a = 0; a <= 'h24; a += 4) begin
            axi_read(6'(a), d, r);
            check($sformatf("reset_reg_0x%02h", a), d, (a == 4) ? 32'h0003_D090 : 32'd0);
            check("rresp_okay", 32'(r), 32'd0);
        end
        for (int i = 0; i < 4; i++) wr(6'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) rd_chk($sformatf("rw_reg_%0d", i), 6'(4 * i), 32'(i + 1));
        wr(6'h00, 32'd0);

        // 2: read-only / unmapped writes and byte strobes
        wr(6'h10, 32'hDEAD_BEEF);
        wr(6'h20, 32'hDEAD_BEEF);
        wr(6'h3C, 32'hDEAD_BEEF);
        rd_chk("ch0_ro", 6'h10, 32'd0);
        rd_chk("status_ro", 6'h20, 32'd0);
        rd_chk("unmapped_3c", 6'h3C, 32'd0);
        wr(6'h0C, 32'd0);
        axi_write(6'h0C, 32'hAABB_CCDD, 4'b0010, r);
        check("strb_bresp", 32'(r), 32'd0);
        rd_chk("scratch_strb", 6'h0C, 32'h0000_CC00);

        // 3: first frame
        wr(6'h04, 32'd500);
        wr(6'h08, 32'd1);
        wr(6'h00, 32'd1);
        last_rise = cyc_n;
        rise_after(20);
        rise_after(1000);
        rise_after(150);
        rise_after(200);
        rise_after(250);
        rise_after(300);
        repeat (10) @(negedge clk);
        check("irq_count_frame1", 32'(irq_cnt), 32'd1);
        check("irq_delay", 32'(irq_cyc - last_rise), 32'd3);
        rd_chk("f1_ch0", 6'h10, 32'd150);
        rd_chk("f1_ch1", 6'h14, 32'd200);
        rd_chk("f1_ch2", 6'h18, 32'd250);
        rd_chk("f1_ch3", 6'h1C, 32'd300);
        rd_chk("f1_status", 6'h20, 32'h0001_0001);

        // 4: short frame discarded, then a complete one
        rise_after(1000);
        rise_after(150);
        rise_after(200);
        rise_after(800);
        rd_chk("short_ch0_kept", 6'h10, 32'd150);
        rd_chk("short_status_kept", 6'h20, 32'h0001_0001);
        rise_after(100);
        rise_after(110);
        rise_after(120);
        rise_after(130);
        repeat (10) @(negedge clk);
        rd_chk("f2_ch0", 6'h10, 32'd100);
        rd_chk("f2_ch1", 6'h14, 32'd110);
        rd_chk("f2_ch2", 6'h18, 32'd120);
        rd_chk("f2_ch3", 6'h1C, 32'd130);
        rd_chk("f2_status", 6'h20, 32'h0001_0002);
        check("irq_count_frame2", 32'(irq_cnt), 32'd2);

        // 5: timeout with a 12-bit counter (saturates at 4095)
        rise_after(1000);
        rise_after(140);
        rise_after(150);
        rise_after(160);
        rise_after(170);
        while (cyc_n < last_rise + 4000) @(negedge clk);
        rd_chk("pre_timeout_status", 6'h20, 32'h0001_0003);
        while (cyc_n < last_rise + 4200) @(negedge clk);
        rd_chk("timeout_status", 6'h20, 32'h0002_0003);
        rd_chk("timeout_ch0_kept", 6'h10, 32'd140);
        wr(6'h00, 32'd1);
        rd_chk("timeout_cleared", 6'h20, 32'h0000_0003);

        // 6: back-pressure, then reset mid-frame
        rise_after(4300);
        rise_after(150);
        @(negedge clk);
        awaddr = 6'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("bp_awready_first", 32'(awready), 32'd1);
        @(posedge clk); #1;
        stay_ok = 1'b1; extra_aw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!bvalid) stay_ok = 1'b0;
            if (awready) extra_aw = 1'b1;
        end
        check("bvalid_held", 32'(stay_ok), 32'd1);
        check("no_second_awready", 32'(extra_aw), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 6'h0C; arvalid = 1'b1;
        @(negedge clk);
        check("bp_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        held = rdata;
        check("bp_rdata_new_scratch", held, 32'h0000_0055);
        stay_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rvalid || rdata !== held) stay_ok = 1'b0;
        end
        check("rvalid_rdata_held", 32'(stay_ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_outputs_zero", {26'd0, awready, wready, bvalid, arready, rvalid, frame_irq}, 32'd0);
        check("reset_rdata_zero", rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_rise = cyc_n;
        rise_after(600);
        rise_after(100);
        repeat (10) @(negedge clk);
        rd_chk("post_reset_ctrl", 6'h00, 32'd0);
        rd_chk("post_reset_sync_min", 6'h04, 32'h0003_D090);
        rd_chk("post_reset_scratch", 6'h0C, 32'd0);
        rd_chk("post_reset_ch0_idle", 6'h10, 32'd0);
        rd_chk("post_reset_status", 6'h20, 32'd0);
        check("irq_count_final", 32'(irq_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
